control_sequencer: RTL and testbench

SAP-1 micro-step sequencer: decodes the instruction register opcode and ALU flags into the per-cycle control word that drives the program counter (count, load, halt), MAR, RAM, IR, A/B registers, ALU and output register. It is the controlling end of the program counter interface: its `o_pc_count`, `o_pc_load` and `o_halt` outputs drive the counter's count-enable, load-enable and halt inputs. It sits between the IR/flags register and every bus participant. It advances one micro-step per enabled clock.

---
 rtl/control_sequencer.sv | 143 ++++++++++++++
 tb/tb_control_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// SAP-1 micro-step sequencer: T0..T4 step counter plus opcode/flag decode into the control word.
// Optional SEQ_SHORT_CYCLE_EN: wrap to T0 right after each instruction's last non-empty step.
module control_sequencer #(
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [3:0]            i_opcode,
  input  logic                  i_flag_carry,
  input  logic                  i_flag_zero,
  output logic [STEP_WIDTH-1:0] o_step,
  output logic                  o_pc_out,
  output logic                  o_pc_count,
  output logic                  o_pc_load,
  output logic                  o_mar_load,
  output logic                  o_ram_out,
  output logic                  o_ram_load,
  output logic                  o_ir_load,
  output logic                  o_ir_out,
  output logic                  o_a_load,
  output logic                  o_a_out,
  output logic                  o_b_load,
  output logic                  o_alu_out,
  output logic                  o_alu_sub,
  output logic                  o_flags_load,
  output logic                  o_out_load,
  output logic                  o_halt
);

  typedef enum logic [STEP_WIDTH-1:0] {T0, T1, T2, T3, T4} step_t;

  typedef struct packed {
    logic pc_out, pc_count, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;
  } ctrl_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE, OP_HLT = 4'hF;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = 1;

`ifdef SEQ_SHORT_CYCLE_EN
  localparam bit SHORT_CYCLE = 1'b1;
`else
  localparam bit SHORT_CYCLE = 1'b0;
`endif

  step_t step_reg, step_next, last_step, stop_step;
  logic  halted_reg, halted_next;
  ctrl_t dec, ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_reg   <= T0;
      halted_reg <= 1'b0;
    end else begin
      step_reg   <= step_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    dec       = '0;
    last_step = T2;
    unique case (step_reg)
      T0:      begin dec.pc_out = 1'b1; dec.mar_load = 1'b1; end
      T1:      begin dec.ram_out = 1'b1; dec.ir_load = 1'b1; dec.pc_count = 1'b1; end
      default: ;
    endcase
    // Execute phase; NOP and the undefined opcodes fall through to default and drive nothing.
    case (i_opcode)
      OP_LDA, OP_STA: begin
        last_step = T3;
        if (step_reg == T2) begin dec.ir_out = 1'b1; dec.mar_load = 1'b1; end
        if (step_reg == T3) begin
          if (i_opcode == OP_LDA) begin dec.ram_out = 1'b1; dec.a_load = 1'b1; end
          else begin dec.a_out = 1'b1; dec.ram_load = 1'b1; end
        end
      end
      OP_ADD, OP_SUB: begin
        last_step = T4;
        if (step_reg == T2) begin dec.ir_out = 1'b1; dec.mar_load = 1'b1; end
        if (step_reg == T3) begin dec.ram_out = 1'b1; dec.b_load = 1'b1; end
        if (step_reg == T4) begin
          dec.alu_out    = 1'b1;
          dec.a_load     = 1'b1;
          dec.flags_load = 1'b1;
          dec.alu_sub    = (i_opcode == OP_SUB);
        end
      end
      OP_LDI: if (step_reg == T2) begin dec.ir_out = 1'b1; dec.a_load = 1'b1; end
      OP_JMP, OP_JC, OP_JZ: begin
        if (step_reg == T2 && (i_opcode == OP_JMP ||
                               (i_opcode == OP_JC && i_flag_carry) ||
                               (i_opcode == OP_JZ && i_flag_zero))) begin
          dec.ir_out  = 1'b1;
          dec.pc_load = 1'b1;
        end
      end
      OP_OUT: if (step_reg == T2) begin dec.a_out = 1'b1; dec.out_load = 1'b1; end
      OP_HLT: if (step_reg == T2) dec.halt = 1'b1;
      default: ;
    endcase

    // Once halted only the halt line stays up, whatever the IR now holds.
    ctrl = dec;
    if (halted_reg) begin
      ctrl      = '0;
      ctrl.halt = 1'b1;
    end

    stop_step   = SHORT_CYCLE ? last_step : T4;
    step_next   = step_reg;
    halted_next = halted_reg;
    if (clk_en && !halted_reg) begin
      if (ctrl.halt)                 halted_next = 1'b1;
      else if (step_reg >= stop_step) step_next  = T0;
      else                           step_next  = step_t'(step_reg + STEP_ONE);
    end

    if (!rst_n) ctrl = '0;
  end

  assign o_step       = rst_n ? step_reg : '0;
  assign o_pc_out     = ctrl.pc_out;
  assign o_pc_count   = ctrl.pc_count;
  assign o_pc_load    = ctrl.pc_load;
  assign o_mar_load   = ctrl.mar_load;
  assign o_ram_out    = ctrl.ram_out;
  assign o_ram_load   = ctrl.ram_load;
  assign o_ir_load    = ctrl.ir_load;
  assign o_ir_out     = ctrl.ir_out;
  assign o_a_load     = ctrl.a_load;
  assign o_a_out      = ctrl.a_out;
  assign o_b_load     = ctrl.b_load;
  assign o_alu_out    = ctrl.alu_out;
  assign o_alu_sub    = ctrl.alu_sub;
  assign o_flags_load = ctrl.flags_load;
  assign o_out_load   = ctrl.out_load;
  assign o_halt       = ctrl.halt;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors push expected step/word,
// a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam logic [15:0] PC_OUT = 16'h8000, PC_COUNT = 16'h4000, PC_LOAD = 16'h2000;
  localparam logic [15:0] MAR_LOAD = 16'h1000, RAM_OUT = 16'h0800, RAM_LOAD = 16'h0400;
  localparam logic [15:0] IR_LOAD = 16'h0200, IR_OUT = 16'h0100, A_LOAD = 16'h0080;
  localparam logic [15:0] A_OUT = 16'h0040, B_LOAD = 16'h0020, ALU_OUT = 16'h0010;
  localparam logic [15:0] ALU_SUB = 16'h0008, FLAGS_LOAD = 16'h0004, OUT_LOAD = 16'h0002;
  localparam logic [15:0] HALT = 16'h0001;

`ifdef SEQ_SHORT_CYCLE_EN
  localparam bit SHORT = 1'b1;
`else
  localparam bit SHORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clk_en, flag_carry, flag_zero;
  logic [3:0] opcode;
  logic [2:0] step;
  logic pc_out, pc_count, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] word;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vec_n = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEP_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_opcode(opcode),
    .i_flag_carry(flag_carry), .i_flag_zero(flag_zero), .o_step(step),
    .o_pc_out(pc_out), .o_pc_count(pc_count), .o_pc_load(pc_load),
    .o_mar_load(mar_load), .o_ram_out(ram_out), .o_ram_load(ram_load),
    .o_ir_load(ir_load), .o_ir_out(ir_out), .o_a_load(a_load), .o_a_out(a_out),
    .o_b_load(b_load), .o_alu_out(alu_out), .o_alu_sub(alu_sub),
    .o_flags_load(flags_load), .o_out_load(out_load), .o_halt(halt)
  );

  wire [15:0] word = {pc_out, pc_count, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
                      a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt};

  // Monitor: one comparison per cycle that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (step !== e.step || word !== e.word) begin
          n_err++;
          $display("FAIL vec%0d: step=%0d word=%h, required step=%0d word=%h",
                   e.id, step, word, e.step, e.word);
        end else begin
          $display("ok   vec%0d: op=%h step=%0d word=%h", e.id, opcode, step, word);
        end
      end
    end
  end

  task automatic cyc(input bit rst, input bit en, input logic [3:0] op, input bit c, input bit z,
                     input logic [2:0] es, input logic [15:0] ew);
    rst_n = rst; clk_en = en; opcode = op; flag_carry = c; flag_zero = z;
    q.push_back('{step: es, word: ew, id: vec_n});
    vec_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op);
    cyc(1, 1, op, 0, 0, 3'd0, PC_OUT | MAR_LOAD);
    cyc(1, 1, op, 0, 0, 3'd1, RAM_OUT | IR_LOAD | PC_COUNT);
  endtask

  // Empty trailing steps that only the fixed-length build executes.
  task automatic pad(input logic [3:0] op, input int last);
    if (!SHORT)
      for (int s = last + 1; s <= 4; s++) cyc(1, 1, op, 0, 0, 3'(s), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; opcode = 4'h1; flag_carry = 1'b0; flag_zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles, then LDA
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'h1, 0, 0, 3'd0, 16'h0000);
    fetch(4'h1);
    cyc(1, 1, 4'h1, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 1, 4'h1, 0, 0, 3'd3, RAM_OUT | A_LOAD);
    pad(4'h1, 3);

    // SUB with clk_en toggling: every step shown twice, held on the disabled cycle
    cyc(1, 1, 4'h3, 0, 0, 3'd0, PC_OUT | MAR_LOAD);
    cyc(1, 0, 4'h3, 0, 0, 3'd1, RAM_OUT | IR_LOAD | PC_COUNT);
    cyc(1, 1, 4'h3, 0, 0, 3'd1, RAM_OUT | IR_LOAD | PC_COUNT);
    cyc(1, 0, 4'h3, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 1, 4'h3, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 0, 4'h3, 0, 0, 3'd3, RAM_OUT | B_LOAD);
    cyc(1, 1, 4'h3, 0, 0, 3'd3, RAM_OUT | B_LOAD);
    cyc(1, 0, 4'h3, 0, 0, 3'd4, ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);
    cyc(1, 1, 4'h3, 0, 0, 3'd4, ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);

    // Conditional jumps: JC untaken, JC taken, JZ taken, flag rising mid-T2
    fetch(4'h7);
    cyc(1, 1, 4'h7, 0, 1, 3'd2, 16'h0000);
    pad(4'h7, 2);
    fetch(4'h7);
    cyc(1, 1, 4'h7, 1, 0, 3'd2, IR_OUT | PC_LOAD);
    pad(4'h7, 2);
    fetch(4'h8);
    cyc(1, 1, 4'h8, 0, 1, 3'd2, IR_OUT | PC_LOAD);
    pad(4'h8, 2);
    fetch(4'h7);
    cyc(1, 0, 4'h7, 0, 0, 3'd2, 16'h0000);
    cyc(1, 1, 4'h7, 1, 0, 3'd2, IR_OUT | PC_LOAD);
    pad(4'h7, 2);

    // Length sequence LDI, NOP, LDA, ADD
    fetch(4'h5);
    cyc(1, 1, 4'h5, 0, 0, 3'd2, IR_OUT | A_LOAD);
    pad(4'h5, 2);
    fetch(4'h0);
    cyc(1, 1, 4'h0, 0, 0, 3'd2, 16'h0000);
    pad(4'h0, 2);
    fetch(4'h1);
    cyc(1, 1, 4'h1, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 1, 4'h1, 0, 0, 3'd3, RAM_OUT | A_LOAD);
    pad(4'h1, 3);
    fetch(4'h2);
    cyc(1, 1, 4'h2, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 1, 4'h2, 0, 0, 3'd3, RAM_OUT | B_LOAD);
    cyc(1, 1, 4'h2, 1, 1, 3'd4, ALU_OUT | A_LOAD | FLAGS_LOAD);

    // STA, JMP, OUT, undefined 0xA
    fetch(4'h4);
    cyc(1, 1, 4'h4, 0, 0, 3'd2, IR_OUT | MAR_LOAD);
    cyc(1, 1, 4'h4, 0, 0, 3'd3, A_OUT | RAM_LOAD);
    pad(4'h4, 3);
    fetch(4'h6);
    cyc(1, 1, 4'h6, 0, 0, 3'd2, IR_OUT | PC_LOAD);
    pad(4'h6, 2);
    fetch(4'hE);
    cyc(1, 1, 4'hE, 0, 0, 3'd2, A_OUT | OUT_LOAD);
    pad(4'hE, 2);
    fetch(4'hA);
    cyc(1, 1, 4'hA, 1, 1, 3'd2, 16'h0000);
    pad(4'hA, 2);

    // Reset mid-instruction
    fetch(4'h1);
    cyc(0, 1, 4'h1, 0, 0, 3'd0, 16'h0000);

    // HLT: frozen at T2 for 20 cycles, IR change and clk_en ignored, cleared by reset
    fetch(4'hF);
    cyc(1, 1, 4'hF, 0, 0, 3'd2, HALT);
    for (int i = 0; i < 20; i++) cyc(1, 1, 4'hF, 0, 0, 3'd2, HALT);
    cyc(1, 0, 4'h2, 1, 1, 3'd2, HALT);
    cyc(1, 1, 4'h6, 0, 0, 3'd2, HALT);
    cyc(0, 1, 4'hF, 0, 0, 3'd0, 16'h0000);
    fetch(4'h5);
    cyc(1, 1, 4'h5, 0, 0, 3'd2, IR_OUT | A_LOAD);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
